// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: access size encodings,
// response state encoding and the misalignment rule.
package mem_arbiter_pkg;

    // Access size (funct3 style) encodings carried on d_ctrl / mem_ctrl
    typedef enum logic [2:0] {
        SIZE_BYTE = 3'b000,
        SIZE_HALF = 3'b001,
        SIZE_WORD = 3'b010
    } size_e;

    // Which port, if any, receives a response on the next cycle
    typedef enum logic [1:0] {
        RESP_IDLE  = 2'd0,
        RESP_FETCH = 2'd1,
        RESP_DATA  = 2'd2
    } resp_state_e;

    // Half-words need bit 0 clear, words need bits [1:0] clear; bytes never fault
    function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (ctrl == SIZE_HALF) begin
            mis = addr_lo[0];
        end else if (ctrl == SIZE_WORD) begin
            mis = (addr_lo != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory.
// slave: arbiter side, master: requester/memory side (testbench).
interface mem_arbiter_if #(
    parameter int WORD_SIZE = 32
);
    // Fetch port
    logic                 if_req;
    logic [WORD_SIZE-1:0] if_addr;
    logic                 if_gnt;
    logic                 if_rvalid;
    logic [WORD_SIZE-1:0] if_rdata;

    // Data port
    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic [2:0]           d_ctrl;
    logic                 d_gnt;
    logic                 d_rvalid;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 d_err;

    // Memory port
    logic                 mem_write_en;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_write_data;
    logic [2:0]           mem_ctrl;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_ctrl,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_write_en, mem_addr, mem_write_data, mem_ctrl,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_ctrl,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_write_en, mem_addr, mem_write_data, mem_ctrl,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arb_prio.sv
// Priority select between fetch and data requesters. Data wins contention
// until it has taken MAX_DATA_STREAK grants in a row while fetch waited;
// then fetch is forced through once. No grant while reset is asserted.
module mem_arb_prio #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic d_req,
    output logic if_gnt,
    output logic d_gnt
);

    localparam int CW = $clog2(MAX_DATA_STREAK + 1);

    logic [CW-1:0] streak_reg;
    logic [CW-1:0] streak_next;
    logic          streak_full;

    assign streak_full = (streak_reg == CW'(MAX_DATA_STREAK));

    // Grant select from live requests and the streak count
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst_n) begin
            if (d_req && !(if_req && streak_full)) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Streak only counts data grants that made a waiting fetch wait longer
    always_comb begin
        streak_next = streak_reg;
        if (if_gnt || !if_req) begin
            streak_next = '0;
        end else if (d_gnt && !streak_full) begin
            streak_next = streak_reg + 1'b1;
        end
    end

    // Streak counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_reg <= '0;
        end else begin
            streak_reg <= streak_next;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single combinational-read memory.
// Grants are combinational; the granted request drives the memory port and
// the read word is captured at the grant edge, giving a one-cycle response.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE       = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);

    logic if_gnt;
    logic d_gnt;
    logic d_misaligned;
    logic unused_fetch_lsbs;

    resp_state_e state_reg;
    resp_state_e state_next;

    logic [WORD_SIZE-1:0] if_rdata_reg;
    logic [WORD_SIZE-1:0] d_rdata_reg;
    logic                 d_err_reg;

    mem_arb_prio #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_prio (
        .clk    (clk),
        .rst_n  (rst_n),
        .if_req (bus.if_req),
        .d_req  (bus.d_req),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt)
    );

    assign d_misaligned = is_misaligned(bus.d_ctrl, bus.d_addr[1:0]);

    // Fetches are silently word-aligned, so the low address bits are dropped
    assign unused_fetch_lsbs = ^bus.if_addr[1:0];

    assign bus.if_gnt = if_gnt;
    assign bus.d_gnt  = d_gnt;

    // Steer the granted request onto the memory port; idle drives all zero
    always_comb begin
        bus.mem_write_en   = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_write_data = '0;
        bus.mem_ctrl       = 3'b000;
        if (if_gnt) begin
            bus.mem_addr = {bus.if_addr[WORD_SIZE-1:2], 2'b00};
            bus.mem_ctrl = SIZE_WORD;
        end else if (d_gnt) begin
            bus.mem_addr       = bus.d_addr;
            bus.mem_ctrl       = bus.d_ctrl;
            bus.mem_write_data = bus.d_wdata;
            bus.mem_write_en   = bus.d_we & ~d_misaligned;
        end
    end

    // Next response owner follows this cycle's grant
    always_comb begin
        state_next = RESP_IDLE;
        if (if_gnt) begin
            state_next = RESP_FETCH;
        end else if (d_gnt) begin
            state_next = RESP_DATA;
        end
    end

    // Response state register; reset drops any response in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RESP_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture read data at the grant edge; the other port keeps its last word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
            d_err_reg    <= 1'b0;
        end else begin
            if (if_gnt) begin
                if_rdata_reg <= bus.mem_rdata;
            end
            if (d_gnt) begin
                d_rdata_reg <= bus.d_we ? '0 : bus.mem_rdata;
            end
            d_err_reg <= d_gnt & d_misaligned;
        end
    end

    assign bus.if_rvalid = (state_reg == RESP_FETCH);
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.d_rvalid  = (state_reg == RESP_DATA);
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.d_err     = d_err_reg;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: WORD_SIZE, default 32, datapath width; MAX_DATA_STREAK, default 4, consecutive contended data grants before fetch is forced.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 if_req  in  1  fetch request. if_addr  in  WORD_SIZE  fetch byte address.
REQ-005 if_gnt  out  1  fetch accepted this cycle. if_rvalid  out  1  fetch response valid. if_rdata  out  WORD_SIZE  fetched word.
REQ-006 d_req  in  1  data request. d_we  in  1  1=store, 0=load. d_addr  in  WORD_SIZE  byte address. d_wdata  in  WORD_SIZE  store data. d_ctrl  in  3  funct3 size (000 byte, 001 half, 010 word).
REQ-007 d_gnt  out  1  data accepted. d_rvalid  out  1  data response valid. d_rdata  out  WORD_SIZE  raw load word. d_err  out  1  misaligned, qualified by d_rvalid.
REQ-008 mem_write_en  out  1. mem_addr  out  WORD_SIZE. mem_write_data  out  WORD_SIZE. mem_ctrl  out  3. mem_rdata  in  WORD_SIZE  combinational read of mem_addr.

Function
REQ-009 Grant SHALL be combinational from current requests and registered state; at most one of if_gnt/d_gnt high per cycle.
REQ-010 Request accepted when req and gnt high in same cycle; requester holds req/addr/data stable until granted.
REQ-011 Arbitration: data only -> data; fetch only -> fetch; both -> data, unless streak counter == MAX_DATA_STREAK, then fetch.
REQ-012 Streak counter increments on each data grant while if_req high; clears on any fetch grant or when if_req low; saturates at MAX_DATA_STREAK.
REQ-013 Memory mux: fetch grant drives mem_addr=if_addr, mem_ctrl=3'b010, mem_write_en=0; data grant drives d_addr, d_ctrl, d_wdata, mem_write_en=d_we & ~misaligned; no grant drives mem_write_en=0, mem_addr=0.
REQ-014 Misaligned: d_ctrl=001 with addr[0]=1, or d_ctrl=010 with addr[1:0]!=0; fetch with if_addr[1:0]!=0 forced aligned by clearing bits [1:0].
REQ-015 Latency: response valid exactly one cycle after grant; mem_rdata registered into if_rdata or d_rdata at grant edge; rvalid is a one-cycle pulse.
REQ-016 Stores SHALL produce d_rvalid=1 next cycle with d_rdata=0; d_err set per REQ-014 for loads and stores.
REQ-017 Throughput one grant per cycle; back-to-back grants to either port allowed.
REQ-018 State machine RESP: IDLE (no response next), FETCH (fetch response pending), DATA (data response pending); next state set from grant each cycle, any state -> IDLE on no grant.
REQ-019 rdata registers of the non-responding port SHALL hold their previous value.

Reset
REQ-020 rst_n low SHALL immediately force state IDLE, streak 0, if_rvalid=0, d_rvalid=0, d_err=0, if_rdata=0, d_rdata=0.
REQ-021 Grant in flight when reset asserts SHALL produce no response; mem_write_en SHALL be 0 while rst_n low.
REQ-022 First grant allowed on first rising edge after rst_n deasserts.

Structure
REQ-023 Shared package SHALL hold size encodings (BYTE 000, HALF 001, WORD 010) and state encoding IDLE/FETCH/DATA.
REQ-024 One sub-module natural: mem_arb_prio (streak counter plus priority select); muxing and response registers in top.

Verification
REQ-025 Fetch only, if_addr=0x8 -> if_gnt same cycle, mem_ctrl=010, next cycle if_rvalid=1, if_rdata=mem word at 0x8.
REQ-026 Both request every cycle, MAX_DATA_STREAK=4 -> grant pattern D,D,D,D,F repeating; no cycle with both grants.
REQ-027 Store d_ctrl=000 addr 0x18 data 0x15 then load same -> write_en one cycle, d_rvalid both, load returns byte 0x15 in bits [7:0].
REQ-028 Store word addr 0x1A -> d_gnt=1, mem_write_en=0, next cycle d_rvalid=1, d_err=1.
REQ-029 rst_n low one cycle after grant -> no rvalid pulse, all outputs zero, grant resumes first edge after release.
